vga_frame_driver: RTL and testbench

- Display-side counterpart to the colour mapper.
- Generates the DrawX/DrawY scan coordinates that the mapper consumes, then captures the mapper's combinational Red/Green/Blue result for that pixel.
- Drives the VGA DAC with registered RGB, hsync, vsync, blank and sync, all delay-aligned to the same pixel.
- Also emits a one-cycle end-of-frame strobe and a frame counter; game logic uses these to step sprite animation counters (player/ball action) once per frame.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_scan_counter.sv | 78 +++++++
 rtl/vga_frame_driver.sv | 126 ++++++++++++
 tb/tb_vga_frame_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Default VGA 640x480@60 timing constants, derived frame totals
//               and the scan-coordinate type shared by the frame driver.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

   // Default horizontal timing, in pixels
   localparam int unsigned c_H_VIS   = 640;
   localparam int unsigned c_H_FP    = 16;
   localparam int unsigned c_H_SYNC  = 96;
   localparam int unsigned c_H_BP    = 48;

   // Default vertical timing, in lines
   localparam int unsigned c_V_VIS   = 480;
   localparam int unsigned c_V_FP    = 10;
   localparam int unsigned c_V_SYNC  = 2;
   localparam int unsigned c_V_BP    = 33;

   // System clocks per pixel (two gives 25 MHz pixels from a 50 MHz Clk)
   localparam int unsigned c_CLK_DIV = 2;

   // Derived totals: 800 pixels per line, 525 lines per frame by default
   localparam int unsigned c_H_TOTAL = c_H_VIS + c_H_FP + c_H_SYNC + c_H_BP;
   localparam int unsigned c_V_TOTAL = c_V_VIS + c_V_FP + c_V_SYNC + c_V_BP;

   // Scan coordinate as seen by the colour mapper
   typedef logic [9:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/vga_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_counter
// Description : Clock divider producing the pixel enable, plus the horizontal
//               and vertical scan counters and the end-of-frame wrap strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_counter
   import vga_pkg::*;
#(
   parameter int unsigned H_TOTAL = c_H_TOTAL,
   parameter int unsigned V_TOTAL = c_V_TOTAL,
   parameter int unsigned CLK_DIV = c_CLK_DIV
) (
   input  logic   Clk,
   input  logic   Reset_n,
   output logic   pix_en_o,
   output logic   pixel_clk_o,
   output coord_t hc_o,
   output coord_t vc_o,
   output logic   wrap_o
);

   localparam int unsigned c_DIV_W = $clog2(CLK_DIV);

   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV / 2);
   localparam coord_t             c_H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t             c_V_LAST   = coord_t'(V_TOTAL - 1);

   logic [c_DIV_W-1:0] div_q, div_d;
   coord_t             hc_q, hc_d;
   coord_t             vc_q, vc_d;
   logic               w_pix_en;
   logic               w_h_last;
   logic               w_v_last;

   // Next-state for divider and counters; counters only move on the pixel enable
   always_comb begin
      w_pix_en = (div_q == c_DIV_LAST);
      w_h_last = (hc_q == c_H_LAST);
      w_v_last = (vc_q == c_V_LAST);
      div_d    = w_pix_en ? '0 : div_q + 1'b1;
      hc_d     = hc_q;
      vc_d     = vc_q;
      if (w_pix_en) begin
         if (w_h_last) begin
            hc_d = '0;
            vc_d = w_v_last ? '0 : vc_q + 1'b1;
         end else begin
            hc_d = hc_q + 1'b1;
         end
      end
   end

   // Divider and scan counter state
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_q <= '0;
         hc_q  <= '0;
         vc_q  <= '0;
      end else begin
         div_q <= div_d;
         hc_q  <= hc_d;
         vc_q  <= vc_d;
      end
   end

   assign pix_en_o    = w_pix_en;
   // Upper half of the divider period is high, giving 50% duty for even dividers
   assign pixel_clk_o = (div_q >= c_DIV_HALF);
   assign hc_o        = hc_q;
   assign vc_o        = vc_q;
   // Last pixel of the last line is being consumed: both counters wrap together
   assign wrap_o      = w_pix_en & w_h_last & w_v_last;

endmodule
`default_nettype wire

// File: rtl/vga_frame_driver.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_driver
// Description : Generates DrawX/DrawY for the colour mapper, registers the
//               mapper RGB together with hsync/vsync/blank so all DAC signals
//               describe the same pixel, and counts completed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_driver
   import vga_pkg::*;
#(
   parameter int unsigned H_VIS   = c_H_VIS,
   parameter int unsigned H_FP    = c_H_FP,
   parameter int unsigned H_SYNC  = c_H_SYNC,
   parameter int unsigned H_BP    = c_H_BP,
   parameter int unsigned V_VIS   = c_V_VIS,
   parameter int unsigned V_FP    = c_V_FP,
   parameter int unsigned V_SYNC  = c_V_SYNC,
   parameter int unsigned V_BP    = c_V_BP,
   parameter int unsigned CLK_DIV = c_CLK_DIV
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [7:0]  Red_in,
   input  logic [7:0]  Green_in,
   input  logic [7:0]  Blue_in,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        pixel_clk,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic        frame_end,
   output logic [15:0] frame_count
);

   localparam int unsigned c_H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned c_V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;

   localparam coord_t      c_H_VIS_X  = coord_t'(H_VIS);
   localparam coord_t      c_HS_START = coord_t'(H_VIS + H_FP);
   localparam coord_t      c_HS_END   = coord_t'(H_VIS + H_FP + H_SYNC);
   localparam coord_t      c_V_VIS_Y  = coord_t'(V_VIS);
   localparam coord_t      c_VS_START = coord_t'(V_VIS + V_FP);
   localparam coord_t      c_VS_END   = coord_t'(V_VIS + V_FP + V_SYNC);

   logic        w_pix_en;
   logic        w_wrap;
   coord_t      w_hc;
   coord_t      w_vc;
   logic        w_hs_raw;
   logic        w_vs_raw;
   logic        w_vis_raw;

   logic [23:0] rgb_d, rgb_q;
   logic        hs_q;
   logic        vs_q;
   logic        blank_n_q;
   logic [15:0] frame_count_d, frame_count_q;

   vga_scan_counter #(
      .H_TOTAL (c_H_TOT),
      .V_TOTAL (c_V_TOT),
      .CLK_DIV (CLK_DIV)
   ) u_scan (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .pix_en_o    (w_pix_en),
      .pixel_clk_o (pixel_clk),
      .hc_o        (w_hc),
      .vc_o        (w_vc),
      .wrap_o      (w_wrap)
   );

   // Raw sync/visible decode for the pixel the mapper is currently colouring
   always_comb begin
      w_hs_raw      = !((w_hc >= c_HS_START) && (w_hc < c_HS_END));
      w_vs_raw      = !((w_vc >= c_VS_START) && (w_vc < c_VS_END));
      w_vis_raw     = (w_hc < c_H_VIS_X) && (w_vc < c_V_VIS_Y);
      // Mapper colour outside the visible area (e.g. sky default) is discarded
      rgb_d         = w_vis_raw ? {Red_in, Green_in, Blue_in} : 24'h0;
      frame_count_d = frame_count_q + 16'd1;
   end

   // DAC stage: colour and timing captured together so they stay pixel-aligned
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rgb_q     <= 24'h0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
      end else if (w_pix_en) begin
         rgb_q     <= rgb_d;
         hs_q      <= w_hs_raw;
         vs_q      <= w_vs_raw;
         blank_n_q <= w_vis_raw;
      end
   end

   // Completed-frame counter, stepping on the wrap strobe and rolling over at 16 bits
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_count_q <= 16'h0;
      end else if (w_wrap) begin
         frame_count_q <= frame_count_d;
      end
   end

   assign DrawX       = w_hc;
   assign DrawY       = w_vc;
   assign VGA_R       = rgb_q[23:16];
   assign VGA_G       = rgb_q[15:8];
   assign VGA_B       = rgb_q[7:0];
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_SYNC_N  = 1'b0;
   assign frame_end   = w_wrap;
   assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_driver
// Description : Scoreboard bench for vga_frame_driver using a reduced raster
//               (15 x 8 with CLK_DIV = 2) so several frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_driver;

   localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
   localparam int V_VIS = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int CLK_DIV = 2;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;   // 15
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;   // 8

   logic        Clk;
   logic        Reset_n = 1'b0;
   logic [7:0]  Red_in = 8'h0, Green_in = 8'h0, Blue_in = 8'h0;
   logic [9:0]  DrawX, DrawY;
   logic        pixel_clk;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
   logic        frame_end;
   logic [15:0] frame_count;

   vga_frame_driver #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .CLK_DIV(CLK_DIV)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
      .DrawX(DrawX), .DrawY(DrawY), .pixel_clk(pixel_clk),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
      .VGA_SYNC_N(VGA_SYNC_N), .frame_end(frame_end), .frame_count(frame_count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [26:0] exp_q[$];

   // Reference raster state: value the DUT holds after the most recent posedge
   int          div_m = 0, hc_m = 0, vc_m = 0;
   logic [15:0] frames_m = 16'h0;
   bit          seen_out = 0;
   bit          preload_en = 0;
   bit          preloaded = 0;
   int          fe_seen = 0, wraps_m = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Expected DAC word {R,G,B,HS,VS,BLANK_N} for pixel (hc,vc) given mapper colour
   function automatic logic [26:0] exp_dac(input int hc, input int vc,
                                           input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
      logic vis, hs, vs;
      vis = (hc < H_VIS) && (vc < V_VIS);
      hs  = !((hc >= H_VIS + H_FP) && (hc < H_VIS + H_FP + H_SYNC));
      vs  = !((vc >= V_VIS + V_FP) && (vc < V_VIS + V_FP + V_SYNC));
      return {vis ? {r, g, b} : 24'h0, hs, vs, vis};
   endfunction

   // Driver: presents mapper colour, checks coordinates/strobes, pushes expectations
   initial begin
      logic       pix, last;
      logic [7:0] r, g, b;
      forever begin
         @(negedge Clk);
         if (!Reset_n) begin
            div_m = 0; hc_m = 0; vc_m = 0; frames_m = 16'h0; seen_out = 0;
            check("rst_hs", VGA_HS, 1);
            check("rst_vs", VGA_VS, 1);
            check("rst_blank_n", VGA_BLANK_N, 0);
            check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
            check("rst_drawxy", {DrawX, DrawY}, 0);
            check("rst_frame_end", frame_end, 0);
            check("rst_frame_count", frame_count, 0);
            check("rst_pixel_clk", pixel_clk, 0);
         end else begin
            pix  = (div_m == CLK_DIV - 1);
            last = pix && (hc_m == H_TOT - 1) && (vc_m == V_TOT - 1);
            check("drawx", DrawX, hc_m);
            check("drawy", DrawY, vc_m);
            check("pixel_clk", pixel_clk, (div_m >= CLK_DIV / 2) ? 1 : 0);
            check("frame_end", frame_end, last);
            check("frame_count", frame_count, frames_m);
            check("sync_n", VGA_SYNC_N, 0);
            if (frame_end) fe_seen++;
            if (!seen_out) begin
               check("pre_hs", VGA_HS, 1);
               check("pre_vs", VGA_VS, 1);
               check("pre_blank_n", VGA_BLANK_N, 0);
               check("pre_rgb", {VGA_R, VGA_G, VGA_B}, 0);
            end
            if (pix) begin
               if (frames_m[0] == 1'b0) begin
                  r = 8'(hc_m); g = 8'h55; b = 8'h55;
               end else begin
                  r = ~8'(hc_m); g = {4'(vc_m), 4'(hc_m)}; b = 8'hA5;
               end
               Red_in = r; Green_in = g; Blue_in = b;
               exp_q.push_back(exp_dac(hc_m, vc_m, r, g, b));
               seen_out = 1;
               div_m = 0;
               if (hc_m == H_TOT - 1) begin
                  hc_m = 0;
                  vc_m = (vc_m == V_TOT - 1) ? 0 : vc_m + 1;
               end else begin
                  hc_m++;
               end
               if (last) begin
                  frames_m = frames_m + 16'd1;
                  wraps_m++;
               end
            end else begin
               // Off-enable cycles carry junk that must never reach the DAC
               Red_in = 8'($urandom); Green_in = 8'($urandom); Blue_in = 8'($urandom);
               div_m++;
            end
            if (preload_en && !preloaded && frames_m == 16'd1 && vc_m == 2 && hc_m == 3) begin
               force dut.frame_count_q = 16'hFFFF;
               #1;
               release dut.frame_count_q;
               frames_m  = 16'hFFFF;
               preloaded = 1;
            end
         end
      end
   end

   // Monitor: each DAC update (pixel_clk falling) is compared against the queue
   initial begin
      logic [26:0] e;
      forever begin
         @(negedge pixel_clk);
         #1;
         if (Reset_n) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL dac_unexpected: got 0x%0h expected none at %0t",
                        {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}, $time);
            end else begin
               e = exp_q.pop_front();
               if ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N} === e) n_pass++;
               else $display("FAIL dac: got 0x%0h expected 0x%0h at %0t",
                             {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}, e, $time);
            end
         end
      end
   end

   // Sequencer: reset, full frame, async reset inside both syncs, counter rollover
   initial begin
      bit ok;
      Reset_n = 1'b0;
      repeat (5) @(posedge Clk);
      #3 Reset_n = 1'b1;

      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge Clk);
         if (frames_m == 16'd1) begin ok = 1; break; end
      end
      n_checks++;
      if (ok) n_pass++; else $display("FAIL first_frame: got timeout expected frame wrap");

      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge Clk);
         #3;
         if (hc_m == 11 && vc_m == 5) begin ok = 1; break; end
      end
      n_checks++;
      if (ok) n_pass++; else $display("FAIL reach_sync: got timeout expected hc=11 vc=5");
      check("in_sync_hs", VGA_HS, 0);
      check("in_sync_vs", VGA_VS, 0);
      Reset_n = 1'b0;
      #1;
      check("async_hs", VGA_HS, 1);
      check("async_vs", VGA_VS, 1);
      check("async_blank_n", VGA_BLANK_N, 0);
      check("async_drawxy", {DrawX, DrawY}, 0);
      check("async_pixel_clk", pixel_clk, 0);
      repeat (3) @(posedge Clk);
      #3 Reset_n = 1'b1;

      preload_en = 1;
      ok = 0;
      for (int i = 0; i < 800; i++) begin
         @(posedge Clk);
         if (preloaded && frames_m == 16'd0) begin ok = 1; break; end
      end
      n_checks++;
      if (ok) n_pass++; else $display("FAIL rollover: got timeout expected frame count wrap");

      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge Clk);
         if (frames_m == 16'd1) begin ok = 1; break; end
      end
      n_checks++;
      if (ok) n_pass++; else $display("FAIL post_rollover: got timeout expected frame wrap");

      repeat (4) @(posedge Clk);
      #3;
      check("queue_drained", exp_q.size(), 0);
      check("frame_end_pulses", fe_seen, wraps_m);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
